// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the instruction-cache
// and data-cache fill FSMs. Grants whole-block fills one at a time, generates
// the word addresses of each fill, steers returning data to the granted side
// and slots data-side write-through stores in between fills.
module mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_write_addr,
  input  logic [DATA_W-1:0] d_write_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic              i_busy,
  output logic              d_busy,
  output logic              d_write_done
);

  // One extra bit so the issue counter can hold WORDS_PER_BLOCK ("all issued").
  localparam int                CNT_W    = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CNT_W-1:0]  N_WORDS  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);
  // Clears the byte offset within a block (block = 2*WORDS_PER_BLOCK bytes).
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic              GRANT_I  = 1'b0;
  localparam logic              GRANT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_ret_cnt;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_base;

  logic                w_fill;
  logic                w_issuing;
  logic                w_ret_last;
  logic [ADDR_W-1:0]   w_word_addr;

  assign w_fill      = (r_state == I_FILL) || (r_state == D_FILL);
  assign w_issuing   = w_fill && (r_issue_cnt < N_WORDS);
  assign w_ret_last  = mem_data_valid && (r_ret_cnt == LAST_IDX);
  // Word addresses step by 2 bytes; the block is aligned so no carry leaves it.
  assign w_word_addr = r_base + (ADDR_W'(r_issue_cnt) << 1);

  assign fill_data = mem_data;
  assign i_busy    = i_miss | (r_state == I_FILL);
  assign d_busy    = d_miss | d_write | (r_state == D_FILL) | (r_state == D_WRITE);

  // Next-state: stores first, then round-robin between two pending misses.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (d_write) begin
          w_next_state = D_WRITE;
        end else if (i_miss && d_miss) begin
          w_next_state = (r_last_grant == GRANT_I) ? D_FILL : I_FILL;
        end else if (i_miss) begin
          w_next_state = I_FILL;
        end else if (d_miss) begin
          w_next_state = D_FILL;
        end
      end
      I_FILL, D_FILL: begin
        if (w_ret_last) begin
          w_next_state = IDLE;
        end
      end
      D_WRITE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory strobes and fill-valid steering; everything held quiet during reset.
  always_comb begin
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    d_write_done = 1'b0;
    case (r_state)
      I_FILL: begin
        mem_enable   = w_issuing;
        mem_addr     = w_issuing ? w_word_addr : '0;
        i_data_valid = mem_data_valid;
      end
      D_FILL: begin
        mem_enable   = w_issuing;
        mem_addr     = w_issuing ? w_word_addr : '0;
        d_data_valid = mem_data_valid;
      end
      D_WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = d_write_addr;
        mem_wdata    = d_write_data;
        d_write_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      i_data_valid = 1'b0;
      d_data_valid = 1'b0;
      d_write_done = 1'b0;
    end
  end

  // Control state: FSM, issue/return counters and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
      r_last_grant <= GRANT_I;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
        if (w_next_state == I_FILL) begin
          r_last_grant <= GRANT_I;
        end else if (w_next_state == D_FILL) begin
          r_last_grant <= GRANT_D;
        end
      end else if (w_fill) begin
        if (w_issuing) begin
          r_issue_cnt <= r_issue_cnt + 1'b1;
        end
        if (mem_data_valid) begin
          r_ret_cnt <= r_ret_cnt + 1'b1;
        end
      end
    end
  end

  // Block base address captured at grant time (datapath, not reset).
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      if (w_next_state == I_FILL) begin
        r_base <= i_miss_addr & BLK_MASK;
      end else if (w_next_state == D_FILL) begin
        r_base <= d_miss_addr & BLK_MASK;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: random requesters plus a fixed-latency memory,
// checked against a transaction-level schedule of expected memory operations
// and fill returns.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_miss, d_miss, d_write, mem_data_valid;
  logic [AW-1:0] i_miss_addr, d_miss_addr, d_write_addr;
  logic [DW-1:0] d_write_data, mem_data;
  logic          mem_enable, mem_wr, i_data_valid, d_data_valid;
  logic          i_busy, d_busy, d_write_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, fill_data;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_write(d_write), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .fill_data(fill_data),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_busy(i_busy), .d_busy(d_busy), .d_write_done(d_write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int cyc;
    bit side;  // 0 = instruction, 1 = data
  } ret_t;

  op_t  exp_op[$];
  ret_t exp_ret[$];
  int   mem_due[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int idle_from = 0;
  bit idle_now = 1'b1;
  bit lg = 1'b0;
  int i_lo = -1, i_hi = -2, d_lo = -1, d_hi = -2;
  int i_rel = -1, d_rel = -1, w_rel = -1;
  int i_gap = 0, d_gap = 0, w_gap = 0;
  bit gen_en = 1'b0;
  int last_grant_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Memory: every read issued in cycle c returns in cycle c+LAT.
  always @(negedge clk) begin
    if (mem_enable === 1'b1 && mem_wr === 1'b0) mem_due.push_back(cyc + LAT);
  end

  // Monitor: compares what the DUT presents against the expected schedule.
  always @(negedge clk) begin
    if (cyc > 0) begin
      op_t  o;
      ret_t r;
      while (exp_op.size() > 0 && exp_op[0].cyc < cyc) begin
        n_vec++; n_err++;
        $display("FAIL op_missing cyc=%0d got=none want_addr=%h at cyc %0d",
                 cyc, exp_op[0].addr, exp_op[0].cyc);
        void'(exp_op.pop_front());
      end
      if (exp_op.size() > 0 && exp_op[0].cyc == cyc) begin
        o = exp_op.pop_front();
        chk("mem_enable", 32'(mem_enable), 32'd1);
        chk("mem_wr", 32'(mem_wr), 32'(o.wr));
        chk("mem_addr", 32'(mem_addr), 32'(o.addr));
        if (o.wr) chk("mem_wdata", 32'(mem_wdata), 32'(o.data));
        chk("d_write_done", 32'(d_write_done), 32'(o.wr));
      end else begin
        chk("mem_enable_quiet", 32'(mem_enable), 32'd0);
        chk("d_write_done_quiet", 32'(d_write_done), 32'd0);
        if (idle_now) begin
          chk("mem_wr_idle", 32'(mem_wr), 32'd0);
          chk("mem_addr_idle", 32'(mem_addr), 32'd0);
          chk("mem_wdata_idle", 32'(mem_wdata), 32'd0);
        end
      end
      while (exp_ret.size() > 0 && exp_ret[0].cyc < cyc) begin
        n_vec++; n_err++;
        $display("FAIL ret_missing cyc=%0d got=none want_cyc=%0d", cyc, exp_ret[0].cyc);
        void'(exp_ret.pop_front());
      end
      if (exp_ret.size() > 0 && exp_ret[0].cyc == cyc) begin
        r = exp_ret.pop_front();
        chk("i_data_valid", 32'(i_data_valid), 32'(r.side == 1'b0));
        chk("d_data_valid", 32'(d_data_valid), 32'(r.side == 1'b1));
        chk("fill_data", 32'(fill_data), 32'(mem_data));
      end else begin
        chk("i_data_valid_quiet", 32'(i_data_valid), 32'd0);
        chk("d_data_valid_quiet", 32'(d_data_valid), 32'd0);
      end
      chk("i_busy", 32'(i_busy), 32'(i_miss | (cyc >= i_lo && cyc <= i_hi)));
      chk("d_busy", 32'(d_busy), 32'(d_miss | d_write | (cyc >= d_lo && cyc <= d_hi)));
    end
  end

  // Start of a cycle: releases, random new requests, memory return drive.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (i_gap > 0) i_gap--;
    if (d_gap > 0) d_gap--;
    if (w_gap > 0) w_gap--;
    if (i_miss && i_rel == cyc) begin i_miss = 1'b0; i_rel = -1; i_gap = int'($urandom_range(1, 8)); end
    if (d_miss && d_rel == cyc) begin d_miss = 1'b0; d_rel = -1; d_gap = int'($urandom_range(1, 8)); end
    if (d_write && w_rel == cyc) begin d_write = 1'b0; w_rel = -1; w_gap = int'($urandom_range(1, 8)); end
    if (gen_en) begin
      if (!i_miss && i_gap == 0 && $urandom_range(0, 5) == 0) begin
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss && d_gap == 0 && $urandom_range(0, 5) == 0) begin
        d_miss = 1'b1; d_miss_addr = 16'($urandom);
      end
      if (!d_write && w_gap == 0 && $urandom_range(0, 9) == 0) begin
        d_write = 1'b1; d_write_addr = 16'($urandom); d_write_data = 16'($urandom);
      end
    end
    mem_data = 16'($urandom);
    mem_data_valid = 1'b0;
    while (mem_due.size() > 0 && mem_due[0] < cyc) void'(mem_due.pop_front());
    if (mem_due.size() > 0 && mem_due[0] == cyc) begin
      mem_data_valid = 1'b1;
      void'(mem_due.pop_front());
    end else if (gen_en && cyc >= idle_from && $urandom_range(0, 7) == 0) begin
      mem_data_valid = 1'b1;  // stray return while idle: must be dropped
    end
  endtask

  // Reset kills anything scheduled from this cycle on.
  task automatic model_reset(input int r);
    while (exp_op.size() > 0 && exp_op[exp_op.size()-1].cyc >= r) void'(exp_op.pop_back());
    while (exp_ret.size() > 0 && exp_ret[exp_ret.size()-1].cyc >= r) void'(exp_ret.pop_back());
    if (i_lo <= r && i_hi >= r) i_hi = r;
    if (d_lo <= r && d_hi >= r) d_hi = r;
    idle_from = r + 1;
    lg = 1'b0;
  endtask

  // Arbitration decision in an idle cycle g, expanded into a service schedule.
  task automatic model_step();
    int            g, end_c;
    bit            side, any;
    logic [AW-1:0] base;
    op_t           o;
    ret_t          r;
    g = cyc;
    idle_now = rst || (g >= idle_from);
    if (rst) begin
      model_reset(g);
    end else if (g >= idle_from) begin
      if (d_write) begin
        o.cyc = g + 1; o.wr = 1'b1; o.addr = d_write_addr; o.data = d_write_data;
        exp_op.push_back(o);
        idle_from = g + 2;
        d_lo = g + 1; d_hi = g + 1;
        w_rel = g + 2;
        last_grant_cyc = g;
      end else begin
        any = 1'b1;
        side = 1'b0;
        if (i_miss && d_miss) side = ~lg;
        else if (i_miss) side = 1'b0;
        else if (d_miss) side = 1'b1;
        else any = 1'b0;
        if (any) begin
          base = (side ? d_miss_addr : i_miss_addr) & ~16'(2 * WPB - 1);
          for (int k = 0; k < WPB; k++) begin
            o.cyc = g + 1 + k; o.wr = 1'b0; o.addr = base + 16'(2 * k); o.data = '0;
            exp_op.push_back(o);
            r.cyc = g + 1 + k + LAT; r.side = side;
            exp_ret.push_back(r);
          end
          end_c = g + WPB + LAT;
          idle_from = end_c + 1;
          lg = side;
          last_grant_cyc = g;
          if (side) begin
            d_lo = g + 1; d_hi = end_c; d_rel = int'($urandom_range(g + 1, end_c + 1));
          end else begin
            i_lo = g + 1; i_hi = end_c; i_rel = int'($urandom_range(g + 1, end_c + 1));
          end
        end
      end
    end
  endtask

  task automatic step();
    begin_cycle();
    model_step();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (!(cyc >= idle_from && !i_miss && !d_miss && !d_write &&
             exp_op.size() == 0 && exp_ret.size() == 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout cyc=%0d got=busy want=idle within %0d cycles", cyc, limit);
    end
  endtask

  initial begin
    int g;
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_write = 1'b0; mem_data_valid = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_write_addr = '0; d_write_data = '0;
    mem_data = '0;
    repeat (3) step();

    // Concurrent misses straight out of reset: data side wins first.
    begin_cycle();
    rst = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_miss = 1'b1; d_miss_addr = 16'($urandom);
    model_step();
    drain(200);

    // Store beats a pending instruction miss.
    begin_cycle();
    d_write = 1'b1; d_write_addr = 16'h0040; d_write_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'($urandom);
    model_step();
    drain(200);

    // Store raised at issue cycle 3 of an instruction fill waits for the fill.
    begin_cycle();
    i_miss = 1'b1; i_miss_addr = 16'($urandom);
    model_step();
    repeat (3) step();
    begin_cycle();
    d_write = 1'b1; d_write_addr = 16'($urandom); d_write_data = 16'($urandom);
    model_step();
    drain(200);

    // Random traffic.
    gen_en = 1'b1;
    repeat (3000) step();
    gen_en = 1'b0;
    drain(400);

    // Reset after five issues of a fill; late returns must be swallowed.
    begin_cycle();
    i_miss = 1'b1; i_miss_addr = 16'($urandom);
    model_step();
    g = cyc;
    i_rel = g + 6;
    repeat (5) step();
    begin_cycle();
    rst = 1'b1;
    model_step();
    begin_cycle();
    rst = 1'b0;
    model_step();
    repeat (12) step();

    chk("leftover_ops", 32'(exp_op.size()), 32'd0);
    chk("leftover_rets", 32'(exp_ret.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction-cache and data-cache controllers and the single shared, pipelined main memory.
- Grants the memory to one client at a time and generates the word addresses for a whole-block fill.
- Routes returning data and valid strobes to the granted client's fill FSM.
- Serialises data-cache write-through stores with fills.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- WORDS_PER_BLOCK, 8, words per cache block; must be a power of 2. A block spans 2*WORDS_PER_BLOCK bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_miss  in  1  instruction-side fill request; level signal.
- i_miss_addr  in  ADDR_W  instruction-side miss address.
- d_miss  in  1  data-side fill request; level signal.
- d_miss_addr  in  ADDR_W  data-side miss address.
- d_write  in  1  data-side write-through store request.
- d_write_addr  in  ADDR_W  store address.
- d_write_data  in  DATA_W  store data.
- mem_data  in  DATA_W  memory read data.
- mem_data_valid  in  1  memory read data valid.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write enable; 1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- fill_data  out  DATA_W  mem_data forwarded to the clients.
- i_data_valid  out  1  fill word valid for the instruction side.
- d_data_valid  out  1  fill word valid for the data side.
- i_busy  out  1  instruction-side request is waiting or in service.
- d_busy  out  1  data-side request is waiting or in service.
- d_write_done  out  1  one-cycle pulse when a store has been issued.

Behaviour:
- Reset: state IDLE; issue and return counters 0; last_grant = I.
- Output values in reset and in IDLE: mem_enable, mem_wr, i_data_valid, d_data_valid, d_write_done all 0; mem_addr and mem_wdata 0.
- States: IDLE, I_FILL, D_FILL, D_WRITE.

Arbitration (IDLE, evaluated each cycle):
- d_write has the highest priority -> D_WRITE.
- Otherwise, with both misses pending, the side not in last_grant wins (round-robin).
- Otherwise the single pending miss wins.
- On grant: latch base = miss_addr with the low log2(2*WORDS_PER_BLOCK) bits cleared; set last_grant.

I_FILL / D_FILL:
- Issue phase: mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
- issue_cnt runs 0..WORDS_PER_BLOCK-1, one word per cycle, with no gaps.
- After WORDS_PER_BLOCK issues, mem_enable=0.
- Each mem_data_valid pulses the granted side's *_data_valid in the same cycle (combinational) and increments ret_cnt.
- When ret_cnt reaches WORDS_PER_BLOCK, the next state is IDLE; the 8th valid is still forwarded.
- A request deasserting mid-fill is ignored; the fill always completes.
- mem_data_valid arriving in IDLE or D_WRITE is discarded; no *_data_valid is raised.

D_WRITE:
- Lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=d_write_addr, mem_wdata=d_write_data.
- d_write_done=1 in the same cycle, then IDLE.
- A store is never started during a fill. It waits in IDLE, with d_busy=1.

Busy and data outputs:
- fill_data = mem_data at all times.
- i_busy = i_miss | (state==I_FILL). d_busy = d_miss | d_write | (state==D_FILL) | (state==D_WRITE).

Timing:
- The arbiter adds no latency. The first address is issued in the cycle after the grant decision.
- Fill duration = WORDS_PER_BLOCK + memory latency cycles.

Address arithmetic:
- Addresses wrap modulo 2^ADDR_W.
- Block alignment guarantees no carry out of the block.

Simultaneous events:
- A request arriving in the cycle a fill finishes is arbitrated in the following IDLE cycle, so there is one IDLE bubble between services.

Reset mid-fill:
- Return to IDLE and clear the counters.
- Outstanding memory returns after reset are discarded, per the IDLE rule.

Test Plan:
- Single I miss: i_miss_addr=0x1236 -> mem_addr 0x1230, 0x1232 ... 0x123E on 8 consecutive cycles, mem_wr=0. With 4-cycle memory latency: 8 i_data_valid pulses, d_data_valid stays 0, then IDLE.
- Concurrent misses from reset: i_miss and d_miss both high, with last_grant=I after reset -> D fill serviced first. The I fill then starts one cycle after the D fill returns to IDLE. No overlap of mem_enable between the two fills.
- Store priority: in IDLE, d_write=1 (addr 0x0040, data 0xBEEF) with i_miss=1 -> one cycle of mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_write_done=1. The I fill begins afterwards.
- Store during fill: d_write asserted at issue cycle 3 of an I fill -> no write until the fill completes. d_busy stays 1, then exactly one write cycle follows.
- Requester drop: i_miss deasserted after 2 issues -> all 8 addresses are still issued and 8 valids forwarded.
- Reset mid-fill: rst pulsed after 5 issues -> next cycle has mem_enable=0 and state IDLE. The 3 late mem_data_valid pulses produce no i_data_valid or d_data_valid.
